// File: rtl/fsc_srl_ctrl_pkg.sv
// Shared types and helpers for the SRL delay-line controller.
//   state_e      : controller FSM states (run, drain in-flight samples, load new depth)
//   clamp_depth  : limits a requested depth to the legal range 1..max_depth
package fsc_srl_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StLoad  = 2'd2
    } state_e;

    function automatic int unsigned clamp_depth(input int unsigned req,
                                                input int unsigned max_depth);
        int unsigned res;
        res = req;
        if (req == 0) begin
            res = 1;
        end else if (req > max_depth) begin
            res = max_depth;
        end
        return res;
    endfunction

endpackage

// File: rtl/fsc_srl_line.sv
// Data shift chain of the delay line plus the output tap mux.
// No reset and enable-only shifting so the chain maps onto SRL primitives.
//   iclk   : clock
//   ien    : shift enable, every stage advances by one
//   idata  : sample entering stage 0
//   itap   : stage index presented on odata (depth - 1)
//   odata  : contents of stage itap
module fsc_srl_line
    import fsc_srl_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               iclk,
    input  logic               ien,
    input  logic [DATA_W-1:0]  idata,
    input  logic [DEPTH_W-1:0] itap,
    output logic [DATA_W-1:0]  odata
);

    logic [DATA_W-1:0] data_q [MAX_DEPTH];

    always_ff @(posedge iclk) begin
        if (ien) begin
            data_q[0] <= idata;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end
    end

    always_comb begin
        odata = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (DEPTH_W'(k) == itap) begin
                odata = data_q[k];
            end
        end
    end

endmodule

// File: rtl/fsc_srl_delay_ctrl.sv
// Controller for a programmable-depth SRL delay line on a valid/ready stream.
// Each accepted sample reappears after 'depth' shift cycles; a depth change
// stops intake, drains the line, loads the new depth and resumes.
//   iclk, irst_n          : clock, async active-low reset
//   ivalid/idata/ordy     : upstream stream
//   ovalid/odata/irdy     : downstream stream (tap at stage depth-1)
//   icfg_valid/icfg_depth : depth change request, accepted when ocfg_ready
//   odepth, ofill         : depth in effect, number of valid stages
//   obusy                 : drain or load in progress
//   oerr                  : one-cycle pulse after a request that had to be clamped
module fsc_srl_delay_ctrl
    import fsc_srl_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned RST_DEPTH = 4,
    parameter int unsigned DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               ivalid,
    input  logic [DATA_W-1:0]  idata,
    output logic               ordy,
    output logic               ovalid,
    output logic [DATA_W-1:0]  odata,
    input  logic               irdy,
    input  logic               icfg_valid,
    input  logic [DEPTH_W-1:0] icfg_depth,
    output logic               ocfg_ready,
    output logic [DEPTH_W-1:0] odepth,
    output logic [DEPTH_W-1:0] ofill,
    output logic               obusy,
    output logic               oerr
);

    state_e               state_q, state_d;
    logic [MAX_DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [DEPTH_W-1:0]   cfg_depth_q, cfg_depth_d;
    logic [DEPTH_W-1:0]   fill_q, fill_d;
    logic                 err_q, err_d;

    logic [DEPTH_W-1:0]   tap;
    logic                 tap_vld;
    logic                 en;
    logic [DEPTH_W-1:0]   req_depth;

    // depth_q is never 0, so the tap index cannot underflow.
    assign tap = depth_q - DEPTH_W'(1);

    always_comb begin
        tap_vld = 1'b0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (DEPTH_W'(k) == tap) begin
                tap_vld = vld_q[k];
            end
        end
    end

    // The line only holds when the output stage is occupied and the sink stalls.
    assign en         = ~tap_vld | irdy;
    assign ordy       = (state_q == StRun) & en;
    assign ocfg_ready = (state_q == StRun);
    assign obusy      = (state_q != StRun);
    assign ovalid     = tap_vld;
    assign odepth     = depth_q;
    assign ofill      = fill_q;
    assign oerr       = err_q;

    assign req_depth = DEPTH_W'(clamp_depth(32'(icfg_depth), MAX_DEPTH));

    fsc_srl_line #(
        .DATA_W   (DATA_W),
        .MAX_DEPTH(MAX_DEPTH),
        .DEPTH_W  (DEPTH_W)
    ) u_line (
        .iclk (iclk),
        .ien  (en),
        .idata(idata),
        .itap (tap),
        .odata(odata)
    );

    // Valid bits and fill count; stages beyond the active depth are forced empty.
    always_comb begin
        vld_d = vld_q;
        if (en) begin
            vld_d = {vld_q[MAX_DEPTH-2:0], ivalid & ordy};
        end
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (DEPTH_W'(k) >= depth_q) begin
                vld_d[k] = 1'b0;
            end
        end
        fill_d = '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            fill_d = fill_d + DEPTH_W'(vld_d[k]);
        end
    end

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        cfg_depth_d = cfg_depth_q;
        err_d       = 1'b0;
        unique case (state_q)
            StRun: begin
                if (icfg_valid) begin
                    cfg_depth_d = req_depth;
                    err_d       = (req_depth != icfg_depth);
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (fill_q == '0) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                depth_d = cfg_depth_q;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q     <= StRun;
            depth_q     <= DEPTH_W'(RST_DEPTH);
            cfg_depth_q <= DEPTH_W'(RST_DEPTH);
            vld_q       <= '0;
            fill_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            cfg_depth_q <= cfg_depth_d;
            vld_q       <= vld_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
        end
    end

endmodule
